// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared register-bus widths and the dump sequencer state encoding,
// also used by the trace formatter.
package regfile_dump_ctrl_pkg;

    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_COUNT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: scans every register through the sampling
// read port and streams (addr, data, last) words over valid/ready.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rse,
    output logic [ADDR_W-1:0] rsaddr,
    input  logic [DATA_W-1:0] rsdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] counter_q, counter_d;
    logic              valid_d, last_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            out_addr  <= addr_d;
            out_data  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        valid_d   = out_valid;
        last_d    = out_last;
        addr_d    = out_addr;
        data_d    = out_data;
        rse       = 1'b0;
        rsaddr    = '0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    counter_d = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                rse    = 1'b1;
                rsaddr = counter_q;
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    data_d  = rsdata;
                    addr_d  = counter_q;
                    last_d  = (counter_q == LAST_ADDR);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                rsaddr = counter_q;
                // abort wins over a same-cycle accept: the word is not delivered
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    if (out_last) begin
                        state_d = FIN;
                    end else begin
                        counter_d = counter_q + 1'b1;
                        state_d   = READ;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file
// (write port plus same-cycle forwarding on the sampling port).
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, rse;
    logic [3:0]  rsaddr;
    logic [15:0] rsdata;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_addr;
    logic [15:0] out_data;
    logic        out_last;

    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] regs [16];

    int errors = 0;
    int checks = 0;

    logic [3:0]  got_addr [32];
    logic [15:0] got_data [32];
    logic        got_last [32];
    logic [15:0] exp_data [16];
    int got_n, done_n, done_cycle, end_cycle, stall_seen, stall_ok;
    bit timed_out;
    logic first_rse;
    logic [3:0] first_rsaddr;

    regfile_dump_ctrl #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rse(rse), .rsaddr(rsaddr), .rsdata(rsdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we && waddr != 4'd0) regs[waddr] <= wdata;

    always_comb begin
        rsdata = '0;
        if (!rst && rsaddr != 4'd0)
            rsdata = (we && waddr == rsaddr) ? wdata : regs[rsaddr];
    end

    task automatic preload();
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 4'(i); wdata = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 16; i++) exp_data[i] = (i == 0) ? 16'h0 : 16'h1000 + 16'(i);
    endtask

    // Starts a dump and runs it until busy drops, steering the consumer and
    // optional events by the address of the word currently offered.
    task automatic run_dump(input int stall_addr, input int stall_n, input logic [15:0] stall_data,
                            input int abort_addr, input int rst_addr, input bit wr_mode,
                            input bit spam);
        bit   wrote2 = 0;
        int   stall_left = stall_n;
        logic d_s, b_s;
        got_n = 0; done_n = 0; done_cycle = -1; end_cycle = -1;
        stall_seen = 0; stall_ok = 0; timed_out = 1;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            d_s = done; b_s = busy;
            if (c == 1) begin first_rse = rse; first_rsaddr = rsaddr; end
            if (d_s) begin done_n++; done_cycle = c; end
            start = spam; abort = 1'b0; we = 1'b0; rst = 1'b0; out_ready = 1'b1;
            if (!b_s) begin
                start = 1'b0; end_cycle = c; timed_out = 0;
                break;
            end
            if (wr_mode) begin
                if (rse && rsaddr == 4'd7) begin
                    we = 1'b1; waddr = 4'd7; wdata = 16'hBEEF;
                end else if (out_valid && out_addr == 4'd2 && !wrote2) begin
                    we = 1'b1; waddr = 4'd2; wdata = 16'h2222; wrote2 = 1;
                end
            end
            if (out_valid && int'(out_addr) == stall_addr && stall_left > 0) begin
                out_ready = 1'b0; stall_left--; stall_seen++;
                if (out_data === stall_data && rse === 1'b0) stall_ok++;
            end
            if (out_valid && int'(out_addr) == abort_addr) abort = 1'b1;
            if (out_valid && int'(out_addr) == rst_addr) begin rst = 1'b1; out_ready = 1'b0; end
            if (out_valid && out_ready && !abort && !rst && got_n < 32) begin
                got_addr[got_n] = out_addr; got_data[got_n] = out_data; got_last[got_n] = out_last;
                got_n++;
            end
        end
        start = 1'b0; abort = 1'b0; we = 1'b0; rst = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, rse, out_valid, out_last} !== 5'b0 || rsaddr !== 4'd0 ||
            out_addr !== 4'd0 || out_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rse=%b valid=%b last=%b rsaddr=%h addr=%h data=%h, required all 0",
                     busy, done, rse, out_valid, out_last, rsaddr, out_addr, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        run_dump(-1, 0, 16'h0, -1, -1, 0, 0);
        checks++;
        if (timed_out || got_n != 16) begin
            errors++; $display("FAIL full_count: got %0d words timeout=%0d, required 16", got_n, timed_out);
        end
        checks++;
        if (first_rse !== 1'b1 || first_rsaddr !== 4'd0) begin
            errors++; $display("FAIL full_first_read: rse=%b rsaddr=%h, required 1/0", first_rse, first_rsaddr);
        end
        for (int i = 0; i < got_n && i < 16; i++) begin
            checks++;
            if (got_addr[i] !== 4'(i) || got_data[i] !== exp_data[i] || got_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL full_word%0d: addr=%h data=%h last=%b, required %h/%h/%b",
                         i, got_addr[i], got_data[i], got_last[i], 4'(i), exp_data[i], i == 15);
            end
        end
        checks++;
        if (done_n != 1 || done_cycle != 33 || end_cycle != 34) begin
            errors++;
            $display("FAIL full_timing: done_n=%0d done_cycle=%0d idle_cycle=%0d, required 1/33/34",
                     done_n, done_cycle, end_cycle);
        end
    endtask

    task automatic test_backpressure();
        run_dump(3, 5, 16'h1003, -1, -1, 0, 0);
        checks++;
        if (stall_seen != 5 || stall_ok != 5) begin
            errors++; $display("FAIL bp_hold: stalled=%0d stable=%0d, required 5/5", stall_seen, stall_ok);
        end
        checks++;
        if (got_n != 16 || got_addr[3] !== 4'd3 || got_addr[4] !== 4'd4 || got_data[4] !== 16'h1004) begin
            errors++;
            $display("FAIL bp_resume: n=%0d addr3=%h addr4=%h data4=%h, required 16/3/4/1004",
                     got_n, got_addr[3], got_addr[4], got_data[4]);
        end
        checks++;
        if (done_n != 1 || done_cycle != 38) begin
            errors++; $display("FAIL bp_done: done_n=%0d cycle=%0d, required 1/38", done_n, done_cycle);
        end
    endtask

    task automatic test_abort();
        run_dump(-1, 0, 16'h0, 9, -1, 0, 0);
        checks++;
        if (timed_out || got_n != 9 || done_n != 0) begin
            errors++; $display("FAIL abort_words: n=%0d done_n=%0d, required 9/0", got_n, done_n);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_state: valid=%b last=%b busy=%b, required 0/0/0", out_valid, out_last, busy);
        end
        run_dump(-1, 0, 16'h0, -1, -1, 0, 0);
        checks++;
        if (got_n != 16 || got_addr[0] !== 4'd0 || got_data[15] !== 16'h100F || done_n != 1) begin
            errors++;
            $display("FAIL abort_restart: n=%0d addr0=%h data15=%h done_n=%0d, required 16/0/100f/1",
                     got_n, got_addr[0], got_data[15], done_n);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rse !== 1'b0) begin
            errors++; $display("FAIL start_abort_idle: busy=%b rse=%b, required 0/0", busy, rse);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_start_while_busy();
        run_dump(-1, 0, 16'h0, -1, -1, 0, 1);
        checks++;
        if (got_n != 16 || done_n != 1 || done_cycle != 33) begin
            errors++; $display("FAIL spam_start: n=%0d done_n=%0d cycle=%0d, required 16/1/33", got_n, done_n, done_cycle);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL spam_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        run_dump(-1, 0, 16'h0, -1, 5, 0, 0);
        checks++;
        if (timed_out || got_n != 5 || done_n != 0) begin
            errors++; $display("FAIL rst_mid_words: n=%0d done_n=%0d, required 5/0", got_n, done_n);
        end
        checks++;
        if ({busy, done, rse, out_valid, out_last} !== 5'b0 || rsaddr !== 4'd0 ||
            out_addr !== 4'd0 || out_data !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b rse=%b valid=%b last=%b rsaddr=%h addr=%h data=%h, required all 0",
                     busy, done, rse, out_valid, out_last, rsaddr, out_addr, out_data);
        end
        run_dump(-1, 0, 16'h0, -1, -1, 0, 0);
        checks++;
        if (got_n != 16 || got_addr[15] !== 4'd15 || got_last[15] !== 1'b1 || done_n != 1) begin
            errors++;
            $display("FAIL rst_mid_restart: n=%0d addr15=%h last15=%b done_n=%0d, required 16/f/1/1",
                     got_n, got_addr[15], got_last[15], done_n);
        end
    endtask

    task automatic test_write_during_scan();
        run_dump(-1, 0, 16'h0, -1, -1, 1, 0);
        checks++;
        if (got_n != 16 || got_data[7] !== 16'hBEEF) begin
            errors++; $display("FAIL wr_forward: n=%0d data7=%h, required 16/beef", got_n, got_data[7]);
        end
        checks++;
        if (got_data[2] !== 16'h1002 || got_data[0] !== 16'h0) begin
            errors++; $display("FAIL wr_after_read: data2=%h data0=%h, required 1002/0", got_data[2], got_data[0]);
        end
        run_dump(-1, 0, 16'h0, -1, -1, 0, 0);
        checks++;
        if (got_data[2] !== 16'h2222 || got_data[7] !== 16'hBEEF) begin
            errors++; $display("FAIL wr_persist: data2=%h data7=%h, required 2222/beef", got_data[2], got_data[7]);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        preload();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_start_abort_idle();
        test_start_while_busy();
        test_reset_mid();
        test_write_during_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
